// File: rtl/tc_fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Holds the FSM state encoding, the address width and the wrapping address adder.
package tc_fetch_pkg;

  localparam int PC_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_e;

  // Word addresses wrap modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_add(input logic [PC_WIDTH-1:0] base,
                                                 input logic [PC_WIDTH-1:0] inc);
    return base + inc;
  endfunction

endpackage

// File: rtl/tc_fetch_assembler.sv
// Instruction assembly buffer: one memory word written per capture, indexed by word slot.
// Word k of the instruction lives in bits [k*WORD_WIDTH +: WORD_WIDTH].
module tc_fetch_assembler #(
  parameter int WORD_WIDTH  = 16,
  parameter int INSTR_WORDS = 2,
  parameter int IDX_W       = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              we,
  input  logic [IDX_W-1:0]                  idx,
  input  logic [WORD_WIDTH-1:0]             wdata,
  output logic [WORD_WIDTH*INSTR_WORDS-1:0] data
);

  logic [INSTR_WORDS-1:0][WORD_WIDTH-1:0] words;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words <= '0;
    end else if (clr) begin
      words <= '0;
    end else if (we) begin
      words[idx] <= wdata;
    end
  end

  assign data = words;

endmodule

// File: rtl/tc_fetch_unit.sv
// Instruction fetch stage: issues word reads to a registered-read program memory,
// assembles INSTR_WORDS words per instruction and hands them off via valid/ready.
module tc_fetch_unit
  import tc_fetch_pkg::*;
#(
  parameter int                   WORD_WIDTH  = 16,
  parameter int                   INSTR_WORDS = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = 16'h0000
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [PC_WIDTH-1:0]               mem_address,
  output logic                              mem_load,
  output logic                              mem_save,
  output logic [WORD_WIDTH-1:0]             mem_wdata,
  input  logic [WORD_WIDTH-1:0]             mem_rdata,
  output logic [WORD_WIDTH*INSTR_WORDS-1:0] instr_data,
  output logic [PC_WIDTH-1:0]               instr_pc,
  output logic                              instr_valid,
  input  logic                              instr_ready,
  input  logic                              redirect_valid,
  input  logic [PC_WIDTH-1:0]               redirect_pc
);

  localparam int                  KW      = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam logic [KW-1:0]       K_LAST  = KW'(INSTR_WORDS - 1);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INSTR_WORDS);

  fetch_state_e        state;
  logic [PC_WIDTH-1:0] pc;
  logic [KW-1:0]       k;
  logic                cap_we;

  // Redirect has priority over every state transition, including a same-edge accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      k     <= '0;
    end else if (redirect_valid) begin
      state <= ST_ISSUE;
      pc    <= redirect_pc;
      k     <= '0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_ISSUE;
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (k == K_LAST) begin
            state <= ST_VALID;
          end else begin
            k     <= k + KW'(1);
            state <= ST_ISSUE;
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            pc    <= pc_add(pc, PC_STEP);
            k     <= '0;
            state <= ST_ISSUE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A read whose data would land on a redirect edge is dropped along with the partial buffer.
  assign cap_we = (state == ST_WAIT) && !redirect_valid;

  tc_fetch_assembler #(
    .WORD_WIDTH  (WORD_WIDTH),
    .INSTR_WORDS (INSTR_WORDS),
    .IDX_W       (KW)
  ) u_asm (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_valid),
    .we    (cap_we),
    .idx   (k),
    .wdata (mem_rdata),
    .data  (instr_data)
  );

  assign mem_address = pc_add(pc, PC_WIDTH'(k));
  assign mem_load    = (state == ST_ISSUE);
  assign mem_save    = 1'b0;
  assign mem_wdata   = '0;
  assign instr_valid = (state == ST_VALID);
  assign instr_pc    = pc;

endmodule

// File: tb/tb_tc_fetch_unit.sv
// Self-checking bench for tc_fetch_unit with a behavioural program memory,
// directed scenarios, then randomized ready/redirect traffic against a transaction model.
module tb_tc_fetch_unit;

  localparam int WW = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   mem_address;
  logic          mem_load;
  logic          mem_save;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata = '0;
  logic [WW*IW-1:0] instr_data;
  logic [15:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [15:0]   redirect_pc = '0;

  int checks = 0;
  int errors = 0;

  tc_fetch_unit #(
    .WORD_WIDTH  (WW),
    .INSTR_WORDS (IW),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_address    (mem_address),
    .mem_load       (mem_load),
    .mem_save       (mem_save),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Program memory contents: fixed words at 0/1, a scrambled pattern elsewhere.
  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1111;
    if (a == 16'h0001) return 16'h2222;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [WW*IW-1:0] expd(input logic [15:0] pc);
    logic [15:0] p1;
    p1 = pc + 16'd1;
    return {memf(p1), memf(pc)};
  endfunction

  // Registered-read memory: data appears the cycle after a load, zero otherwise.
  always @(posedge clk) mem_rdata <= mem_load ? memf(mem_address) : '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_load"},  64'(mem_load), 64'd0);
    chk({tag, "_addr"},  64'(mem_address), 64'h0000);
    chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_data"},  64'(instr_data), 64'd0);
    chk({tag, "_pc"},    64'(instr_pc), 64'h0000);
    chk({tag, "_wr"},    64'({mem_save, mem_wdata}), 64'd0);
  endtask

  initial begin
    logic [15:0] exp_pc;
    int          age;
    logic        drv_redir, drv_ready, vb;
    logic [15:0] drv_rpc;

    // Reset state
    #1 rst = 1'b0;
    tick();
    tick();
    chk_reset_outputs("rst");
    instr_ready = 1'b1;
    rst = 1'b1;

    // First instruction after release: loads at 0 then 1, valid after E5
    tick(); chk("e1_load", 64'(mem_load), 64'd1); chk("e1_addr", 64'(mem_address), 64'h0);
    tick(); chk("e2_load", 64'(mem_load), 64'd0);
    tick(); chk("e3_load", 64'(mem_load), 64'd1); chk("e3_addr", 64'(mem_address), 64'h1);
    instr_ready = 1'b0;
    tick(); chk("e4_valid", 64'(instr_valid), 64'd0);
    tick();
    chk("e5_valid", 64'(instr_valid), 64'd1);
    chk("e5_data", 64'(instr_data), 64'h2222_1111);
    chk("e5_pc", 64'(instr_pc), 64'h0000);

    // Stall: hold for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 64'(instr_valid), 64'd1);
      chk("stall_data", 64'(instr_data), 64'h2222_1111);
      chk("stall_load", 64'(mem_load), 64'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("acc_load", 64'(mem_load), 64'd1);
    chk("acc_addr", 64'(mem_address), 64'h0002);
    chk("acc_valid", 64'(instr_valid), 64'd0);
    tick(); tick(); tick(); tick();
    chk("i2_valid", 64'(instr_valid), 64'd1);
    chk("i2_pc", 64'(instr_pc), 64'h0002);
    chk("i2_data", 64'(instr_data), 64'(expd(16'h0002)));

    // Redirect during WAIT of word 1
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick(); tick();
    chk("w1_addr", 64'(mem_address), 64'h0005);
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    chk("rd_load", 64'(mem_load), 64'd1);
    chk("rd_addr", 64'(mem_address), 64'h0040);
    chk("rd_valid", 64'(instr_valid), 64'd0);
    tick(); tick(); tick(); tick();
    chk("rd_ivalid", 64'(instr_valid), 64'd1);
    chk("rd_pc", 64'(instr_pc), 64'h0040);
    chk("rd_data", 64'(instr_data), 64'(expd(16'h0040)));

    // Redirect on the same edge as accept
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    instr_ready = 1'b0; redirect_valid = 1'b0;
    chk("ra_addr", 64'(mem_address), 64'h0100);
    chk("ra_load", 64'(mem_load), 64'd1);
    tick(); tick(); tick(); tick();
    chk("ra_pc", 64'(instr_pc), 64'h0100);
    chk("ra_data", 64'(instr_data), 64'(expd(16'h0100)));

    // Address wrap at FFFF
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    chk("wr_addr0", 64'(mem_address), 64'hFFFF);
    tick(); tick();
    chk("wr_load1", 64'(mem_load), 64'd1);
    chk("wr_addr1", 64'(mem_address), 64'h0000);
    tick(); tick();
    chk("wr_pc", 64'(instr_pc), 64'hFFFF);
    chk("wr_data", 64'(instr_data), 64'(expd(16'hFFFF)));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("wr_next", 64'(mem_address), 64'h0001);
    tick(); tick();

    // Asynchronous reset mid-ISSUE
    chk("ar_pre", 64'(mem_load), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("ar");
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    chk("ar_rl", 64'(mem_load), 64'd1);
    chk("ar_ra", 64'(mem_address), 64'h0000);

    // Randomized traffic against a transaction-level model
    exp_pc = '0;
    age = 0;
    for (int i = 0; i < 3000; i++) begin
      drv_redir = (i == 0) || ($urandom_range(0, 15) == 0);
      drv_rpc   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + 16'($urandom_range(0, 3)))
                                              : 16'($urandom);
      drv_ready = ($urandom_range(0, 3) != 0);
      vb = instr_valid;
      redirect_valid = drv_redir;
      redirect_pc    = drv_rpc;
      instr_ready    = drv_ready;
      tick();
      if (drv_redir) begin
        exp_pc = drv_rpc;
        age = 0;
      end else if (vb && drv_ready) begin
        exp_pc = exp_pc + 16'd2;
        age = 0;
      end else if (age < 4) begin
        age++;
      end
      chk("r_valid", 64'(instr_valid), 64'(age == 4));
      chk("r_load", 64'(mem_load), 64'((age == 0) || (age == 2)));
      chk("r_wr", 64'({mem_save, mem_wdata}), 64'd0);
      if (age == 0 || age == 2)
        chk("r_addr", 64'(mem_address), 64'(16'(exp_pc + 16'(age / 2))));
      if (age == 4) begin
        chk("r_pc", 64'(instr_pc), 64'(exp_pc));
        chk("r_data", 64'(instr_data), 64'(expd(exp_pc)));
      end
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
